// File: rtl/branch_resolve_if.sv
// Handshake bundle between the execute-stage branch resolver, the issue side,
// the shared ALU comparator and the PC/trap consumer.
interface branch_resolve_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_kind;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] req_imm;
  logic [XLEN-1:0] req_rs1;

  logic            cmp_req;
  logic            cmp_valid;
  logic            cmp_equ;
  logic            cmp_lt;
  logic            cmp_ltu;

  logic            res_valid;
  logic            res_ready;
  logic            res_taken;
  logic [XLEN-1:0] res_target;
  logic [XLEN-1:0] res_link;
  logic            res_misalign;
  logic            res_illegal;
  logic            res_timeout;
  logic            flush;

  // Environment side: issue, comparator and result consumer.
  modport master (
    output req_valid, req_kind, req_funct3, req_pc, req_imm, req_rs1,
    input  req_ready,
    input  cmp_req,
    output cmp_valid, cmp_equ, cmp_lt, cmp_ltu,
    input  res_valid, res_taken, res_target, res_link,
    input  res_misalign, res_illegal, res_timeout, flush,
    output res_ready
  );

  // Resolver side.
  modport slave (
    input  req_valid, req_kind, req_funct3, req_pc, req_imm, req_rs1,
    output req_ready,
    output cmp_req,
    input  cmp_valid, cmp_equ, cmp_lt, cmp_ltu,
    output res_valid, res_taken, res_target, res_link,
    output res_misalign, res_illegal, res_timeout, flush,
    input  res_ready
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Execute-stage control-transfer resolver: IDLE -> (CMP) -> RESP.
// Conditional branches borrow the shared ALU comparator; jumps and illegal
// requests go straight to RESP. The result is held until accepted, and a
// taken, aligned, legal redirect raises flush in the handshake cycle.
module branch_resolve_ctrl #(
  parameter int XLEN        = 32,
  parameter int IALIGN      = 32,
  parameter int CMP_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kill,
  branch_resolve_if.slave  bus
);
  localparam int CW = (CMP_TIMEOUT > 1) ? $clog2(CMP_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

  state_t          state;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] tgt_q;
  logic [XLEN-1:0] link_q;
  logic [CW-1:0]   cnt;
  logic            flush_ok;

  logic            accept;
  logic            illegal_in;
  logic [XLEN-1:0] seq_in;
  logic [XLEN-1:0] jtgt_in;
  logic            j_mis;
  logic            cmp_tk;
  logic            br_mis;

  // funct3[2:1] picks the flag, funct3[0] inverts it.
  function automatic logic cond_taken(input logic [2:0] f3, input logic equ,
                                      input logic lt, input logic ltu);
    logic r;
    case (f3[2:1])
      2'b00:   r = equ;
      2'b10:   r = lt;
      2'b11:   r = ltu;
      default: r = 1'b0;
    endcase
    return r ^ f3[0];
  endfunction

  assign accept        = bus.req_valid & bus.req_ready;
  assign bus.req_ready = (state == IDLE) & ~rst;
  // Flush belongs to the handshake cycle itself, so it is qualified live.
  assign bus.flush     = bus.res_valid & bus.res_ready & flush_ok & ~kill & ~rst;

  // Decode of the incoming request and of the pending branch outcome.
  always_comb begin
    illegal_in = (bus.req_kind == 2'b11) ||
                 (bus.req_kind == 2'b00 && bus.req_funct3[2:1] == 2'b01);
    seq_in     = bus.req_pc + XLEN'(4);
    jtgt_in    = (bus.req_kind == 2'b10) ? ((bus.req_rs1 + bus.req_imm) & ~XLEN'(1))
                                         : (bus.req_pc + bus.req_imm);
    j_mis      = (IALIGN == 32) && jtgt_in[1];
    cmp_tk     = cond_taken(f3_q, bus.cmp_equ, bus.cmp_lt, bus.cmp_ltu);
    br_mis     = (IALIGN == 32) && tgt_q[1];
  end

  // Resolver FSM with registered result outputs; kill and reset abort alike.
  always_ff @(posedge clk) begin
    if (rst || kill) begin
      state            <= IDLE;
      cnt              <= '0;
      flush_ok         <= 1'b0;
      bus.cmp_req      <= 1'b0;
      bus.res_valid    <= 1'b0;
      bus.res_taken    <= 1'b0;
      bus.res_target   <= '0;
      bus.res_link     <= '0;
      bus.res_misalign <= 1'b0;
      bus.res_illegal  <= 1'b0;
      bus.res_timeout  <= 1'b0;
    end else begin
      bus.cmp_req <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          f3_q             <= bus.req_funct3;
          tgt_q            <= bus.req_pc + bus.req_imm;
          link_q           <= seq_in;
          cnt              <= '0;
          bus.res_link     <= seq_in;
          bus.res_timeout  <= 1'b0;
          if (illegal_in) begin
            state            <= RESP;
            bus.res_valid    <= 1'b1;
            bus.res_taken    <= 1'b0;
            bus.res_target   <= seq_in;
            bus.res_misalign <= 1'b0;
            bus.res_illegal  <= 1'b1;
            flush_ok         <= 1'b0;
          end else if (bus.req_kind == 2'b00) begin
            state            <= CMP;
            bus.cmp_req      <= 1'b1;
          end else begin
            state            <= RESP;
            bus.res_valid    <= 1'b1;
            bus.res_taken    <= 1'b1;
            bus.res_target   <= jtgt_in;
            bus.res_misalign <= j_mis;
            bus.res_illegal  <= 1'b0;
            flush_ok         <= ~j_mis;
          end
        end
        CMP: begin
          if (bus.cmp_valid) begin
            state            <= RESP;
            bus.res_valid    <= 1'b1;
            bus.res_taken    <= cmp_tk;
            bus.res_target   <= cmp_tk ? tgt_q : link_q;
            bus.res_misalign <= cmp_tk & br_mis;
            bus.res_illegal  <= 1'b0;
            flush_ok         <= cmp_tk & ~br_mis;
          end else if (CMP_TIMEOUT != 0 && cnt == CW'(CMP_TIMEOUT - 1)) begin
            state            <= RESP;
            bus.res_valid    <= 1'b1;
            bus.res_taken    <= 1'b0;
            bus.res_target   <= link_q;
            bus.res_misalign <= 1'b0;
            bus.res_illegal  <= 1'b0;
            bus.res_timeout  <= 1'b1;
            flush_ok         <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: if (bus.res_ready) begin
          state            <= IDLE;
          flush_ok         <= 1'b0;
          bus.res_valid    <= 1'b0;
          bus.res_taken    <= 1'b0;
          bus.res_target   <= '0;
          bus.res_link     <= '0;
          bus.res_misalign <= 1'b0;
          bus.res_illegal  <= 1'b0;
          bus.res_timeout  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: two instances (IALIGN 32 and 16) share one
// stimulus stream; a transaction-level model predicts each result.
module tb_branch_resolve_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic kill;
  int   n_chk = 0;
  int   n_fail = 0;

  branch_resolve_if #(.XLEN(32)) bus0 ();
  branch_resolve_if #(.XLEN(32)) bus1 ();

  branch_resolve_ctrl #(.XLEN(32), .IALIGN(32), .CMP_TIMEOUT(16)) u_dut32 (
    .clk(clk), .rst(rst), .kill(kill), .bus(bus0));
  branch_resolve_ctrl #(.XLEN(32), .IALIGN(16), .CMP_TIMEOUT(16)) u_dut16 (
    .clk(clk), .rst(rst), .kill(kill), .bus(bus1));

  assign bus1.req_valid  = bus0.req_valid;
  assign bus1.req_kind   = bus0.req_kind;
  assign bus1.req_funct3 = bus0.req_funct3;
  assign bus1.req_pc     = bus0.req_pc;
  assign bus1.req_imm    = bus0.req_imm;
  assign bus1.req_rs1    = bus0.req_rs1;
  assign bus1.cmp_valid  = bus0.cmp_valid;
  assign bus1.cmp_equ    = bus0.cmp_equ;
  assign bus1.cmp_lt     = bus0.cmp_lt;
  assign bus1.cmp_ltu    = bus0.cmp_ltu;
  assign bus1.res_ready  = bus0.res_ready;

  always #5 clk = ~clk;

  typedef struct packed {
    logic        taken;
    logic [31:0] tgt;
    logic [31:0] link;
    logic        mis32;
    logic        mis16;
    logic        ill;
    logic        to;
    logic        fl32;
    logic        fl16;
    logic        ncr;
    logic [7:0]  lat;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Result predicted from the architectural rules; d = cycles from the
  // comparator request to its answer, negative meaning it never answers.
  function automatic exp_t model(input logic [1:0] kind, input logic [2:0] f3,
                                 input logic [31:0] pc, imm, rs1, a, b, input int d);
    exp_t e;
    logic [31:0] raw;
    logic cond;
    e.ill  = (kind == 2'b11) || (kind == 2'b00 && (f3 == 3'b010 || f3 == 3'b011));
    cond   = (kind == 2'b00) && !e.ill;
    e.to   = cond && (d < 0 || d >= 16);
    e.ncr  = cond;
    e.lat  = !cond ? 8'd1 : e.to ? 8'd17 : 8'(d + 2);
    e.link = pc + 32'd4;
    if (e.ill || e.to)    e.taken = 1'b0;
    else if (kind != 0)   e.taken = 1'b1;
    else begin
      case (f3)
        3'b000:  e.taken = (a == b);
        3'b001:  e.taken = (a != b);
        3'b100:  e.taken = ($signed(a) <  $signed(b));
        3'b101:  e.taken = ($signed(a) >= $signed(b));
        3'b110:  e.taken = (a <  b);
        default: e.taken = (a >= b);
      endcase
    end
    raw   = (kind == 2'b10) ? (((rs1 + imm) >> 1) << 1) : (pc + imm);
    e.tgt = e.taken ? raw : pc + 32'd4;
    e.mis32 = e.taken && e.tgt[1];
    e.mis16 = 1'b0;
    e.fl32  = e.taken && !e.mis32 && !e.ill && !e.to;
    e.fl16  = e.taken && !e.ill && !e.to;
    return e;
  endfunction

  task automatic run(input logic [1:0] kind, input logic [2:0] f3,
                     input logic [31:0] pc, imm, rs1, a, b,
                     input int d, input int hold, input bit khs);
    exp_t e;
    int   lat = 0, ncr = 0, crc = 0;
    bit   got = 0, bad = 0;
    logic [31:0] s_tgt, s_link;
    logic [3:0]  s_fl;
    e = model(kind, f3, pc, imm, rs1, a, b, d);
    @(negedge clk);
    bus0.req_valid = 1'b1; bus0.req_kind = kind; bus0.req_funct3 = f3;
    bus0.req_pc = pc; bus0.req_imm = imm; bus0.req_rs1 = rs1;
    bus0.cmp_valid = 1'($urandom);  // ignored while idle
    bus0.cmp_equ = 1'($urandom); bus0.cmp_lt = 1'($urandom); bus0.cmp_ltu = 1'($urandom);
    #1 chk("req_ready", 32'(bus0.req_ready), 32'd1);
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      bus0.req_valid = 1'b0; bus0.req_kind = 2'($urandom); bus0.req_pc = $urandom;
      bus0.cmp_valid = (c == 1 + d);
      if (c == 1 + d) begin
        bus0.cmp_equ = (a == b); bus0.cmp_lt = ($signed(a) < $signed(b)); bus0.cmp_ltu = (a < b);
      end else begin
        bus0.cmp_equ = 1'($urandom); bus0.cmp_lt = 1'($urandom); bus0.cmp_ltu = 1'($urandom);
      end
      #1;
      if (bus0.cmp_req) begin ncr++; crc = c; end
      if (bus0.res_valid) begin got = 1; lat = c; end
    end
    chk("latency", 32'(lat), 32'(e.lat));
    chk("cmp_req_count", 32'(ncr), 32'(e.ncr));
    if (e.ncr) chk("cmp_req_cycle", 32'(crc), 32'd1);
    if (!got) begin
      @(negedge clk); kill = 1'b1;
      @(negedge clk); kill = 1'b0;
      return;
    end
    chk("taken", 32'(bus0.res_taken), 32'(e.taken));
    chk("target", bus0.res_target, e.tgt);
    chk("link", bus0.res_link, e.link);
    chk("misalign32", 32'(bus0.res_misalign), 32'(e.mis32));
    chk("misalign16", 32'(bus1.res_misalign), 32'(e.mis16));
    chk("illegal", 32'(bus0.res_illegal), 32'(e.ill));
    chk("timeout", 32'(bus0.res_timeout), 32'(e.to));
    s_tgt = bus0.res_target; s_link = bus0.res_link;
    s_fl  = {bus0.res_taken, bus0.res_misalign, bus0.res_illegal, bus0.res_timeout};
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      bus0.res_ready = 1'b0; bus0.cmp_valid = 1'($urandom);
      #1;
      if (!bus0.res_valid || bus0.req_ready || bus0.flush || bus0.cmp_req ||
          bus0.res_target !== s_tgt || bus0.res_link !== s_link ||
          {bus0.res_taken, bus0.res_misalign, bus0.res_illegal, bus0.res_timeout} !== s_fl)
        bad = 1;
    end
    if (hold > 0) chk("hold_stable", 32'(bad), 32'd0);
    @(negedge clk);
    bus0.res_ready = 1'b1; bus0.cmp_valid = 1'b0; kill = khs;
    #1;
    chk("flush32", 32'(bus0.flush), 32'(e.fl32 && !khs));
    chk("flush16", 32'(bus1.flush), 32'(e.fl16 && !khs));
    @(negedge clk);
    bus0.res_ready = 1'b0; kill = 1'b0;
    #1;
    chk("post_valid", 32'(bus0.res_valid), 32'd0);
    chk("post_ready", 32'(bus0.req_ready), 32'd1);
  endtask

  initial begin
    bit any;
    rst = 1'b1; kill = 1'b0;
    bus0.req_valid = 0; bus0.req_kind = 0; bus0.req_funct3 = 0;
    bus0.req_pc = 0; bus0.req_imm = 0; bus0.req_rs1 = 0;
    bus0.cmp_valid = 0; bus0.cmp_equ = 0; bus0.cmp_lt = 0; bus0.cmp_ltu = 0;
    bus0.res_ready = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(bus0.req_ready), 32'd0);
    chk("rst_valid", 32'(bus0.res_valid), 32'd0);
    chk("rst_outs", {bus0.cmp_req, bus0.flush, bus0.res_taken, bus0.res_illegal,
                     bus0.res_timeout, bus0.res_misalign}, 32'd0);
    chk("rst_target", bus0.res_target, 32'd0);
    @(negedge clk); rst = 1'b0;
    #1 chk("rel_ready", 32'(bus0.req_ready), 32'd1);

    // Directed cases.
    run(2'b00, 3'b000, 32'h100, 32'h20, 0, 32'd7, 32'd7, 2, 0, 0);        // BEQ taken
    run(2'b00, 3'b101, 32'h200, 32'h40, 0, 32'd5, 32'd3, 0, 1, 0);        // BGE taken
    run(2'b00, 3'b111, 32'h300, 32'h40, 0, 32'd1, 32'd2, 1, 0, 0);        // BGEU not taken
    run(2'b10, 3'b000, 32'h400, 32'h4, 32'h2003, 0, 0, 0, 0, 0);          // jalr misaligned
    run(2'b01, 3'b000, 32'hFFFF_FFF0, 32'h20, 0, 0, 0, 0, 5, 0);          // jal wrap, held
    run(2'b00, 3'b100, 32'h500, 32'h8, 0, 32'd1, 32'd9, -1, 0, 0);        // never answers
    run(2'b00, 3'b100, 32'h500, 32'h8, 0, 32'hFFFF_FFFF, 32'd1, 15, 0, 0); // last-chance answer
    run(2'b00, 3'b010, 32'h600, 32'h8, 0, 0, 0, 0, 0, 0);                 // illegal funct3
    run(2'b11, 3'b000, 32'h700, 32'h8, 0, 0, 0, 0, 0, 0);                 // reserved kind
    run(2'b01, 3'b000, 32'h800, 32'h10, 0, 0, 0, 0, 2, 1);                // kill at handshake

    // Kill while waiting in CMP, then a stale comparator answer.
    @(negedge clk);
    bus0.req_valid = 1; bus0.req_kind = 2'b00; bus0.req_funct3 = 3'b000;
    bus0.req_pc = 32'h900; bus0.req_imm = 32'h10;
    @(negedge clk); bus0.req_valid = 0;
    #1 chk("kill_cmp_req", 32'(bus0.cmp_req), 32'd1);
    @(negedge clk); kill = 1'b1;
    @(negedge clk); kill = 1'b0; bus0.cmp_valid = 1; bus0.cmp_equ = 1;
    #1 chk("kill_ready", 32'(bus0.req_ready), 32'd1);
    any = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bus0.cmp_valid = 0;
      #1 if (bus0.res_valid || bus0.cmp_req) any = 1;
    end
    chk("kill_no_result", 32'(any), 32'd0);

    // Reset while a result is waiting, with the consumer accepting.
    @(negedge clk);
    bus0.req_valid = 1; bus0.req_kind = 2'b01; bus0.req_pc = 32'hA00; bus0.req_imm = 32'h40;
    @(negedge clk); bus0.req_valid = 0;
    @(negedge clk); rst = 1'b1; bus0.res_ready = 1'b1;
    #1;
    chk("midrst_ready", 32'(bus0.req_ready), 32'd0);
    chk("midrst_flush", 32'(bus0.flush), 32'd0);
    @(negedge clk); bus0.res_ready = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus0.res_valid), 32'd0);
    chk("midrst_ready2", 32'(bus0.req_ready), 32'd0);
    @(negedge clk); rst = 1'b0;
    #1 chk("midrst_release", 32'(bus0.req_ready), 32'd1);

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  k;
      logic [31:0] a, b;
      int d;
      k = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 17));
      run(k, 3'($urandom), $urandom, $urandom, $urandom, a, b, d,
          int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule
